pipibibs_snd_m68k_if: RTL

// 68k-side initiator into the Z80 sound subsystem: turns 68k bus cycles into sound-command pushes and shared-RAM accesses.

---
 rtl/pipibibs_snd_m68k_if_if.sv | 35 +++
 rtl/pipibibs_snd_m68k_if.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipibibs_snd_m68k_if_if.sv
// Bus bundle between the 68k address decoder, the Z80 sound side and the shared SRAM.
// The slave modport is the initiator block; the master modport is its surroundings.
interface pipibibs_snd_m68k_if_if #(
  parameter int unsigned AW = 11
) ();
  logic          m_latch_cs;
  logic          m_ram_cs;
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din;
  logic [7:0]    m_dout;
  logic          m_dtack_n;
  logic          z_latch_rd;
  logic [7:0]    soundlatch;
  logic          z80int;
  logic          z_ram_busy;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_din;
  logic          sram_we;
  logic [7:0]    sram_data;
  logic [4:0]    fifo_level;
  logic          overflow;

  modport slave (
    input  m_latch_cs, m_ram_cs, m_rw, m_addr, m_din, z_latch_rd, z_ram_busy, sram_data,
    output m_dout, m_dtack_n, soundlatch, z80int, sram_addr, sram_din, sram_we,
           fifo_level, overflow
  );

  modport master (
    output m_latch_cs, m_ram_cs, m_rw, m_addr, m_din, z_latch_rd, z_ram_busy, sram_data,
    input  m_dout, m_dtack_n, soundlatch, z80int, sram_addr, sram_din, sram_we,
           fifo_level, overflow
  );
endinterface

// File: rtl/pipibibs_snd_m68k_if.sv
// 68k-side initiator into the Z80 sound subsystem: command FIFO driving the sound latch,
// plus an arbitrated access path into the 2 KB shared sound SRAM.
module pipibibs_snd_m68k_if #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 11
) (
  input logic                  clk,
  input logic                  rst,
  pipibibs_snd_m68k_if_if.slave bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = 5;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_ACK
  } state_t;

  state_t          state_q, state_d;
  logic            latch_cs_q, ram_cs_q, z_rd_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   sram_addr_q, sram_addr_d;
  logic [7:0]      sram_din_q, sram_din_d;
  logic            sram_we_q, sram_we_d;
  logic [7:0]      m_dout_q, m_dout_d;
  logic            ram_ack_d;
  logic            latch_ack_q, latch_ack_d;
  logic            dtack_n_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      soundlatch_q, soundlatch_d;
  logic            z80int_q, overflow_q;
  logic            do_push, do_pop, ovf_set;

  logic latch_edge, push_edge, pop_edge, ram_edge;

  // The latch select has priority; a RAM edge coinciding with it is discarded.
  assign latch_edge = bus.m_latch_cs & ~latch_cs_q;
  assign push_edge  = latch_edge & ~bus.m_rw;
  assign pop_edge   = bus.z_latch_rd & ~z_rd_q;
  assign ram_edge   = bus.m_ram_cs & ~ram_cs_q & ~bus.m_latch_cs;

  // RAM access sequencer and 68k read-data mux.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    sram_we_d   = 1'b0;
    m_dout_d    = m_dout_q;
    ram_ack_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ram_edge) begin
          state_d = S_WAIT;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_din;
          rw_d    = bus.m_rw;
        end
      end
      S_WAIT: begin
        if (!bus.z_ram_busy) begin
          sram_addr_d = addr_q;
          if (!rw_q) begin
            sram_we_d  = 1'b1;
            sram_din_d = wdata_q;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (rw_q) begin
          state_d = S_CAPTURE;
        end else begin
          state_d   = bus.m_ram_cs ? S_ACK : S_IDLE;
          ram_ack_d = bus.m_ram_cs;
        end
      end
      S_CAPTURE: begin
        m_dout_d  = bus.sram_data;
        state_d   = bus.m_ram_cs ? S_ACK : S_IDLE;
        ram_ack_d = bus.m_ram_cs;
      end
      S_ACK: begin
        if (bus.m_ram_cs) ram_ack_d = 1'b1;
        else              state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (latch_edge && bus.m_rw) m_dout_d = {7'b0, z80int_q};
  end

  // Latch-register acknowledge: held from the edge until the select is released.
  always_comb begin
    latch_ack_d = latch_ack_q;
    if (latch_edge)           latch_ack_d = 1'b1;
    else if (!bus.m_latch_cs) latch_ack_d = 1'b0;
  end

  // Command FIFO bookkeeping; a pop frees the slot a same-cycle push needs.
  always_comb begin
    do_pop   = pop_edge && (level_q != '0);
    do_push  = push_edge && ((level_q != FULL_LVL) || do_pop);
    ovf_set  = push_edge && (level_q == FULL_LVL) && !do_pop;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    level_d  = level_q;
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (!do_push && do_pop) level_d = level_q - LW'(1);
    soundlatch_d = soundlatch_q;
    if (level_d != '0) begin
      soundlatch_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? bus.m_din : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= bus.m_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      latch_cs_q   <= 1'b0;
      ram_cs_q     <= 1'b0;
      z_rd_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      sram_we_q    <= 1'b0;
      m_dout_q     <= '0;
      latch_ack_q  <= 1'b0;
      dtack_n_q    <= 1'b1;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      soundlatch_q <= '0;
      z80int_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_cs_q   <= bus.m_latch_cs;
      ram_cs_q     <= bus.m_ram_cs;
      z_rd_q       <= bus.z_latch_rd;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      sram_we_q    <= sram_we_d;
      m_dout_q     <= m_dout_d;
      latch_ack_q  <= latch_ack_d;
      dtack_n_q    <= ~(latch_ack_d | ram_ack_d);
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      soundlatch_q <= soundlatch_d;
      z80int_q     <= (level_d != '0);
      overflow_q   <= overflow_q | ovf_set;
    end
  end

  assign bus.m_dout     = m_dout_q;
  assign bus.m_dtack_n  = dtack_n_q;
  assign bus.soundlatch = soundlatch_q;
  assign bus.z80int     = z80int_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_din   = sram_din_q;
  assign bus.sram_we    = sram_we_q;
  assign bus.fifo_level = level_q;
  assign bus.overflow   = overflow_q;

endmodule
